// File: rtl/control_fsm_gen.sv
// control_fsm_gen: control-unit FSM for the single-cycle-datapath processor.
// Sequences fetch / decode / execute and produces every datapath control
// (PC, IR, data memory, register file, ALU). Adds LOADI, AND, OR, BRZ, a
// configurable data-memory read latency, a Run stall, a resumable HALT, a
// sticky illegal-opcode flag and a saturating decoded-instruction counter.
// Parameter constraints: IW >= OPW+3*RAW, IW >= OPW+RAW+DAW,
// PCW <= IW-OPW-RAW, MEM_LAT >= 1, OPW >= 4.
module control_fsm_gen #(
    parameter int IW      = 16,
    parameter int OPW     = 4,
    parameter int RAW     = 4,
    parameter int DAW     = 8,
    parameter int PCW     = 8,
    parameter int MEM_LAT = 1,
    parameter int CNTW    = 16,
    localparam int IMMW   = IW - OPW - RAW
) (
    input  logic            Clk,
    input  logic            resetN,
    input  logic [IW-1:0]   IR,
    input  logic            Run,
    input  logic            Resume,
    input  logic            Ra_zero,
    output logic            PC_up,
    output logic            PC_clr,
    output logic            PC_ld,
    output logic [PCW-1:0]  PC_target,
    output logic            IR_ld,
    output logic [DAW-1:0]  D_Addr,
    output logic            D_wr,
    output logic [1:0]      RF_s,
    output logic [IMMW-1:0] RF_imm,
    output logic [RAW-1:0]  RF_W_addr,
    output logic [RAW-1:0]  RF_Ra_addr,
    output logic [RAW-1:0]  RF_Rb_addr,
    output logic            RF_W_en,
    output logic [2:0]      ALU_s,
    output logic            Illegal,
    output logic            Halted,
    output logic [CNTW-1:0] InstrCnt,
    output logic [3:0]      OutState,
    output logic [3:0]      NextState
);

    // Wait counter only needs to count 0 .. MEM_LAT-1.
    localparam int WAITW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_LOAD_A = 4'd3,
        S_LOAD_B = 4'd4,
        S_ADD    = 4'd5,
        S_SUB    = 4'd6,
        S_STORE  = 4'd7,
        S_NOOP   = 4'd8,
        S_HALT   = 4'd9,
        S_LOADI  = 4'd10,
        S_AND    = 4'd11,
        S_OR     = 4'd12,
        S_BRZ    = 4'd13
    } state_t;

    localparam logic [OPW-1:0] OP_NOOP  = OPW'(0);
    localparam logic [OPW-1:0] OP_STORE = OPW'(1);
    localparam logic [OPW-1:0] OP_LOAD  = OPW'(2);
    localparam logic [OPW-1:0] OP_ADD   = OPW'(3);
    localparam logic [OPW-1:0] OP_SUB   = OPW'(4);
    localparam logic [OPW-1:0] OP_HALT  = OPW'(5);
    localparam logic [OPW-1:0] OP_LOADI = OPW'(6);
    localparam logic [OPW-1:0] OP_AND   = OPW'(7);
    localparam logic [OPW-1:0] OP_OR    = OPW'(8);
    localparam logic [OPW-1:0] OP_BRZ   = OPW'(9);

    localparam logic [WAITW-1:0] WAIT_LAST = WAITW'(MEM_LAT - 1);

    state_t            state_q, state_d;
    logic              illegal_q, illegal_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [WAITW-1:0]  wait_q, wait_d;

    // Instruction fields
    logic [OPW-1:0]    opcode;
    logic [RAW-1:0]    fld_ra;
    logic [RAW-1:0]    fld_rb;
    logic [RAW-1:0]    fld_rd;
    logic [DAW-1:0]    fld_ld_addr;
    logic [DAW-1:0]    fld_st_addr;
    logic [IMMW-1:0]   fld_imm;
    logic [PCW-1:0]    fld_target;

    assign opcode      = IR[IW-1 -: OPW];
    assign fld_ra      = IR[IW-OPW-1 -: RAW];
    assign fld_rb      = IR[IW-OPW-RAW-1 -: RAW];
    assign fld_rd      = IR[RAW-1:0];
    assign fld_ld_addr = IR[IW-OPW-1 -: DAW];
    assign fld_st_addr = IR[DAW-1:0];
    assign fld_imm     = IR[IW-OPW-1:RAW];
    assign fld_target  = IR[PCW-1:0];

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNTW'(1);
    endfunction

    // Next-state, sticky flag, instruction counter and load-wait counter.
    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        wait_d    = wait_q;
        case (state_q)
            S_INIT: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (Run) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                cnt_d  = sat_inc(cnt_q);
                // Clear here so every LOAD_A visit starts counting from zero.
                wait_d = '0;
                case (opcode)
                    OP_NOOP:  state_d = S_NOOP;
                    OP_STORE: state_d = S_STORE;
                    OP_LOAD:  state_d = S_LOAD_A;
                    OP_ADD:   state_d = S_ADD;
                    OP_SUB:   state_d = S_SUB;
                    OP_HALT:  state_d = S_HALT;
                    OP_LOADI: state_d = S_LOADI;
                    OP_AND:   state_d = S_AND;
                    OP_OR:    state_d = S_OR;
                    OP_BRZ:   state_d = S_BRZ;
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_LOAD_A: begin
                if (wait_q == WAIT_LAST) begin
                    wait_d  = '0;
                    state_d = S_LOAD_B;
                end else begin
                    wait_d = wait_q + WAITW'(1);
                end
            end
            S_HALT: begin
                if (Resume) begin
                    state_d = S_FETCH;
                end
            end
            S_LOAD_B, S_ADD, S_SUB, S_STORE, S_NOOP,
            S_LOADI, S_AND, S_OR, S_BRZ: begin
                state_d = S_FETCH;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    // State and control registers; synchronous active-low reset wins over all.
    always_ff @(posedge Clk) begin
        if (!resetN) begin
            state_q   <= S_INIT;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
            wait_q    <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
        end
    end

    // Datapath controls decoded from the current state and instruction fields.
    always_comb begin
        PC_up      = 1'b0;
        PC_clr     = 1'b0;
        PC_ld      = 1'b0;
        PC_target  = '0;
        IR_ld      = 1'b0;
        D_Addr     = '0;
        D_wr       = 1'b0;
        RF_s       = 2'd0;
        RF_imm     = '0;
        RF_W_addr  = '0;
        RF_Ra_addr = '0;
        RF_Rb_addr = '0;
        RF_W_en    = 1'b0;
        ALU_s      = 3'd0;
        Halted     = 1'b0;
        case (state_q)
            S_INIT: begin
                PC_clr = 1'b1;
            end
            S_FETCH: begin
                IR_ld = Run;
                PC_up = Run;
            end
            S_LOAD_A: begin
                D_Addr = fld_ld_addr;
            end
            S_LOAD_B: begin
                D_Addr    = fld_ld_addr;
                RF_s      = 2'd1;
                RF_W_addr = fld_rd;
                RF_W_en   = 1'b1;
            end
            S_ADD, S_SUB, S_AND, S_OR: begin
                RF_Ra_addr = fld_ra;
                RF_Rb_addr = fld_rb;
                RF_W_addr  = fld_rd;
                RF_W_en    = 1'b1;
                case (state_q)
                    S_ADD:   ALU_s = 3'd1;
                    S_SUB:   ALU_s = 3'd2;
                    S_AND:   ALU_s = 3'd3;
                    default: ALU_s = 3'd4;
                endcase
            end
            S_STORE: begin
                RF_Ra_addr = fld_ra;
                D_Addr     = fld_st_addr;
                D_wr       = 1'b1;
            end
            S_LOADI: begin
                RF_s      = 2'd2;
                RF_imm    = fld_imm;
                RF_W_addr = fld_rd;
                RF_W_en   = 1'b1;
            end
            S_BRZ: begin
                // PC_up/PC_clr are never active here, so PC_ld cannot collide.
                RF_Ra_addr = fld_ra;
                PC_target  = fld_target;
                PC_ld      = Ra_zero;
            end
            S_HALT: begin
                Halted = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign Illegal   = illegal_q;
    assign InstrCnt  = cnt_q;
    assign OutState  = state_q;
    assign NextState = state_d;

endmodule

// File: tb/tb_control_fsm_gen.sv
// Randomized self-checking bench for control_fsm_gen. An instruction-level
// reference model expands each instruction into its expected per-cycle trace
// (state codes, controls, counters). A second instance with a 2-bit counter
// exposes InstrCnt saturation.
module tb_control_fsm_gen;

    localparam int MLAT = 3;

    logic        Clk = 1'b0;
    logic        resetN, Run, Resume, Ra_zero;
    logic [15:0] IR;

    // Main instance outputs
    logic       PC_up, PC_clr, PC_ld, IR_ld, D_wr, RF_W_en, Illegal, Halted;
    logic [7:0] PC_target, D_Addr, RF_imm;
    logic [1:0] RF_s;
    logic [3:0] RF_W_addr, RF_Ra_addr, RF_Rb_addr, OutState, NextState;
    logic [2:0] ALU_s;
    logic [15:0] InstrCnt;

    // Saturation instance outputs
    logic       s_PC_up, s_PC_clr, s_PC_ld, s_IR_ld, s_D_wr, s_RF_W_en, s_Illegal, s_Halted;
    logic [7:0] s_PC_target, s_D_Addr, s_RF_imm;
    logic [1:0] s_RF_s;
    logic [3:0] s_RF_W_addr, s_RF_Ra_addr, s_RF_Rb_addr, s_OutState, s_NextState;
    logic [2:0] s_ALU_s;
    logic [1:0] s_InstrCnt;

    control_fsm_gen #(.MEM_LAT(MLAT)) u_dut (
        .Clk(Clk), .resetN(resetN), .IR(IR), .Run(Run), .Resume(Resume), .Ra_zero(Ra_zero),
        .PC_up(PC_up), .PC_clr(PC_clr), .PC_ld(PC_ld), .PC_target(PC_target), .IR_ld(IR_ld),
        .D_Addr(D_Addr), .D_wr(D_wr), .RF_s(RF_s), .RF_imm(RF_imm), .RF_W_addr(RF_W_addr),
        .RF_Ra_addr(RF_Ra_addr), .RF_Rb_addr(RF_Rb_addr), .RF_W_en(RF_W_en), .ALU_s(ALU_s),
        .Illegal(Illegal), .Halted(Halted), .InstrCnt(InstrCnt), .OutState(OutState),
        .NextState(NextState)
    );

    control_fsm_gen #(.MEM_LAT(MLAT), .CNTW(2)) u_sat (
        .Clk(Clk), .resetN(resetN), .IR(IR), .Run(Run), .Resume(Resume), .Ra_zero(Ra_zero),
        .PC_up(s_PC_up), .PC_clr(s_PC_clr), .PC_ld(s_PC_ld), .PC_target(s_PC_target),
        .IR_ld(s_IR_ld), .D_Addr(s_D_Addr), .D_wr(s_D_wr), .RF_s(s_RF_s), .RF_imm(s_RF_imm),
        .RF_W_addr(s_RF_W_addr), .RF_Ra_addr(s_RF_Ra_addr), .RF_Rb_addr(s_RF_Rb_addr),
        .RF_W_en(s_RF_W_en), .ALU_s(s_ALU_s), .Illegal(s_Illegal), .Halted(s_Halted),
        .InstrCnt(s_InstrCnt), .OutState(s_OutState), .NextState(s_NextState)
    );

    always #5 Clk = ~Clk;

    logic [63:0] obs_m, obs_s;
    assign obs_m = {16'd0, PC_up, PC_clr, PC_ld, PC_target, IR_ld, D_Addr, D_wr, RF_s, RF_imm,
                    RF_W_addr, RF_Ra_addr, RF_Rb_addr, RF_W_en, ALU_s, Halted};
    assign obs_s = {16'd0, s_PC_up, s_PC_clr, s_PC_ld, s_PC_target, s_IR_ld, s_D_Addr, s_D_wr,
                    s_RF_s, s_RF_imm, s_RF_W_addr, s_RF_Ra_addr, s_RF_Rb_addr, s_RF_W_en,
                    s_ALU_s, s_Halted};

    int errors = 0;
    int checks = 0;
    int m_cnt  = 0;
    bit m_ill  = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Opcode -> execute state code; undefined opcodes return to FETCH.
    function automatic int op_to_state(input int op);
        case (op)
            0: return 8;  1: return 7;  2: return 3;  3: return 5;  4: return 6;
            5: return 9;  6: return 10; 7: return 11; 8: return 12; 9: return 13;
            default: return 1;
        endcase
    endfunction

    // Expected control vector for a state code, using the default field map.
    function automatic logic [63:0] exp_out(input int code, input logic [15:0] ir,
                                            input logic raz, input logic run);
        logic pu, pc, pl, il, dw, we, h;
        logic [7:0] tg, da, im;
        logic [1:0] rs;
        logic [3:0] wa, ra, rb;
        logic [2:0] al;
        {pu, pc, pl, il, dw, we, h} = '0;
        {tg, da, im, rs, wa, ra, rb, al} = '0;
        case (code)
            0: pc = 1'b1;
            1: begin il = run; pu = run; end
            3: da = ir[11:4];
            4: begin da = ir[11:4]; rs = 2'd1; we = 1'b1; wa = ir[3:0]; end
            5, 6, 11, 12: begin
                ra = ir[11:8]; rb = ir[7:4]; wa = ir[3:0]; we = 1'b1;
                al = (code == 5) ? 3'd1 : (code == 6) ? 3'd2 : (code == 11) ? 3'd3 : 3'd4;
            end
            7: begin ra = ir[11:8]; da = ir[7:0]; dw = 1'b1; end
            9: h = 1'b1;
            10: begin rs = 2'd2; im = ir[11:4]; wa = ir[3:0]; we = 1'b1; end
            13: begin ra = ir[11:8]; tg = ir[7:0]; pl = raz; end
            default: ;
        endcase
        return {16'd0, pu, pc, pl, tg, il, da, dw, rs, im, wa, ra, rb, we, al, h};
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // mode: 0/1 fixed value, 2 random
    task automatic set_in(input int run_m, input int res_m, input int raz_m);
        Run     = (run_m == 2) ? 1'($urandom % 2) : 1'(run_m);
        Resume  = (res_m == 2) ? 1'($urandom % 2) : 1'(res_m);
        Ra_zero = (raz_m == 2) ? 1'($urandom % 2) : 1'(raz_m);
    endtask

    // Check one cycle of both instances, then advance to the next cycle.
    task automatic cyc(input string tag, input int code, input int nxt);
        logic [63:0] e;
        #1;
        e = exp_out(code, IR, Ra_zero, Run);
        check({tag, "_state"},   64'(OutState),    64'(code));
        check({tag, "_next"},    64'(NextState),   64'(nxt));
        check({tag, "_ctl"},     obs_m,            e);
        check({tag, "_s_state"}, 64'(s_OutState),  64'(code));
        check({tag, "_s_ctl"},   obs_s,            e);
        tick();
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_illegal"},   64'(Illegal),    64'(m_ill));
        check({tag, "_s_illegal"}, 64'(s_Illegal),  64'(m_ill));
        check({tag, "_cnt"},       64'(InstrCnt),   64'((m_cnt > 65535) ? 65535 : m_cnt));
        check({tag, "_sat_cnt"},   64'(s_InstrCnt), 64'((m_cnt > 3) ? 3 : m_cnt));
    endtask

    task automatic do_reset(input int n);
        resetN = 1'b0;
        set_in(2, 2, 2);
        repeat (n) tick();
        m_cnt = 0;
        m_ill = 1'b0;
        #1;
        check("rst_state",   64'(OutState),   64'd0);
        check("rst_s_state", 64'(s_OutState), 64'd0);
        check_counters("rst");
        resetN = 1'b1;
        set_in(2, 2, 2);
        cyc("init", 0, 1);
    endtask

    // FETCH (with optional stall) and DECODE of one instruction.
    task automatic fetch_decode(input logic [15:0] ir, input int stall, input int raz_m);
        int op;
        IR = ir;
        op = int'(ir[15:12]);
        for (int s = 0; s < stall; s++) begin
            set_in(0, 2, raz_m);
            cyc("fetch_stall", 1, 1);
        end
        set_in(1, 2, raz_m);
        cyc("fetch", 1, 2);
        set_in(2, 2, raz_m);
        cyc("decode", 2, op_to_state(op));
        m_cnt++;
        if (op > 9) m_ill = 1'b1;
        check_counters("decode");
    endtask

    task automatic do_instr(input logic [15:0] ir, input int stall, input int hold,
                            input int raz_m);
        int code;
        fetch_decode(ir, stall, raz_m);
        code = op_to_state(int'(ir[15:12]));
        if (code == 3) begin
            for (int k = 0; k < MLAT; k++) begin
                set_in(2, 2, raz_m);
                cyc("load_a", 3, (k == MLAT - 1) ? 4 : 3);
            end
            set_in(2, 2, raz_m);
            cyc("load_b", 4, 1);
        end else if (code == 9) begin
            for (int h = 0; h < hold; h++) begin
                set_in(2, 0, raz_m);
                cyc("halt", 9, 9);
            end
            set_in(2, 1, raz_m);
            cyc("halt_exit", 9, 1);
        end else if (code != 1) begin
            set_in(2, 2, raz_m);
            cyc("exec", code, 1);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN  = 1'b0;
        Run     = 1'b0;
        Resume  = 1'b0;
        Ra_zero = 1'b0;
        IR      = 16'h0000;
        do_reset(2);

        // Directed instructions
        do_instr(16'h1234, 0, 0, 2);
        do_instr(16'h2AB5, 0, 0, 2);
        do_instr(16'h6C37, 0, 0, 2);
        do_instr(16'h8123, 0, 0, 2);
        do_instr(16'h3456, 0, 0, 2);
        do_instr(16'h4789, 0, 0, 2);
        do_instr(16'h7ABC, 0, 0, 2);
        do_instr(16'h9240, 0, 0, 1);
        do_instr(16'h9240, 0, 0, 0);
        do_instr(16'hF000, 0, 0, 2);
        do_instr(16'h0000, 4, 0, 2);
        do_instr(16'h5000, 0, 3, 2);
        do_instr(16'hA123, 1, 0, 2);

        // Reset in the middle of a LOAD
        fetch_decode(16'h2AB5, 0, 2);
        set_in(2, 2, 2);
        cyc("load_a_pre_rst", 3, 3);
        do_reset(1);

        // Reset while halted
        fetch_decode(16'h5000, 0, 2);
        set_in(2, 0, 2);
        cyc("halt_pre_rst", 9, 9);
        do_reset(1);

        // Randomized instruction stream
        for (int n = 0; n < 150; n++) begin
            do_instr(16'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 2);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
